// File: rtl/dispatch_pkg.sv
// Shared types and field widths for the job dispatcher and its helpers.
package dispatch_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } dispatch_state_e;

  localparam int DES_ADDR_W   = 64;
  localparam int COMP_LEN_W   = 35;
  localparam int DECOMP_LEN_W = 32;
  localparam int SRC_ADDR_W   = 64;
  localparam int JOB_ID_W     = 16;

endpackage

// File: rtl/rr_free_select.sv
// Round-robin free-slot picker: first set bit of free_mask at or after rr_ptr, wrapping.
module rr_free_select #(
  parameter int NUM   = 4,
  parameter int IDX_W = 2
) (
  input  logic [NUM-1:0]   free_mask,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic             any_free,
  output logic [IDX_W-1:0] sel
);

  int idx;

  always_comb begin
    any_free = |free_mask;
    sel      = rr_ptr;
    idx      = 0;
    // Scan from the far end back so the candidate nearest rr_ptr is written last.
    for (int k = NUM - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr) + k) % NUM;
      if (free_mask[idx]) sel = IDX_W'(idx);
    end
  end

endmodule

// File: rtl/job_dispatch_ctrl.sv
// Round-robin dispatcher from the pending-job queue to NUM_ENGINES engines, with a serialised
// completion stream. Define DISPATCH_WATCHDOG_EN to add per-engine timeouts and the timeout output.
//
// state    | meaning
// ST_IDLE  | waiting for a pending job, a free engine and hold low; pops the head on dispatch
// ST_ISSUE | registered descriptor on the eng_* bus; pulses eng_start for the selected engine
module job_dispatch_ctrl
  import dispatch_pkg::*;
#(
  parameter int NUM_ENGINES = 4,
  parameter int ENG_IDX_W   = 2
`ifdef DISPATCH_WATCHDOG_EN
  ,
  parameter int TIMEOUT_CYCLES = 65535
`endif
) (
  input  logic                    clk,
  input  logic                    srst,
  input  logic                    pend_valid,
  output logic                    pend_rd,
  input  logic [DES_ADDR_W-1:0]   pend_des_addr,
  input  logic [COMP_LEN_W-1:0]   pend_comp_len,
  input  logic [DECOMP_LEN_W-1:0] pend_decomp_len,
  input  logic [SRC_ADDR_W-1:0]   pend_src_addr,
  input  logic [JOB_ID_W-1:0]     pend_job_id,
  input  logic                    hold,
  output logic [NUM_ENGINES-1:0]  eng_start,
  output logic [DES_ADDR_W-1:0]   eng_des_addr,
  output logic [COMP_LEN_W-1:0]   eng_comp_len,
  output logic [DECOMP_LEN_W-1:0] eng_decomp_len,
  output logic [SRC_ADDR_W-1:0]   eng_src_addr,
  output logic [JOB_ID_W-1:0]     eng_job_id,
  input  logic [NUM_ENGINES-1:0]  eng_done,
  output logic [NUM_ENGINES-1:0]  busy_mask,
  output logic                    done_valid,
  output logic [ENG_IDX_W-1:0]    done_engine,
  output logic [JOB_ID_W-1:0]     done_job_id,
  output logic                    spurious_done,
  output logic                    all_idle
`ifdef DISPATCH_WATCHDOG_EN
  ,
  output logic                    timeout
`endif
);

  dispatch_state_e state_q, state_d;

  logic [ENG_IDX_W-1:0]   rr_ptr;
  logic [ENG_IDX_W-1:0]   sel_q;
  logic [ENG_IDX_W-1:0]   sel_nxt;
  logic [ENG_IDX_W-1:0]   rpt_idx;
  logic                   sel_any;
  logic                   dispatch;
  logic                   issue;
  logic                   rpt_any;
  logic [NUM_ENGINES-1:0] busy, busy_d;
  logic [NUM_ENGINES-1:0] free_mask;
  logic [NUM_ENGINES-1:0] done_pend, pend_eff, pend_d;
  logic [NUM_ENGINES-1:0] done_hit;
  logic [JOB_ID_W-1:0]    job_tbl [NUM_ENGINES];

  assign free_mask = ~busy;
  assign busy_mask = busy;
  assign all_idle  = (state_q == ST_IDLE) && (busy == '0) && (done_pend == '0);

  rr_free_select #(
    .NUM   (NUM_ENGINES),
    .IDX_W (ENG_IDX_W)
  ) u_rr_free_select (
    .free_mask (free_mask),
    .rr_ptr    (rr_ptr),
    .any_free  (sel_any),
    .sel       (sel_nxt)
  );

  always_comb begin
    state_d   = state_q;
    pend_rd   = 1'b0;
    eng_start = '0;
    dispatch  = 1'b0;
    issue     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pend_valid && !hold && sel_any) begin
          pend_rd  = 1'b1;
          dispatch = 1'b1;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        eng_start[sel_q] = 1'b1;
        issue            = 1'b1;
        state_d          = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef DISPATCH_WATCHDOG_EN
  // The hit fires on the cycle whose increment would reach the limit, so done_pend sets
  // at the same edge the counter reaches TIMEOUT_CYCLES.
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0]            wd_cnt [NUM_ENGINES];
  logic [NUM_ENGINES-1:0] wd_hit, to_pend, to_eff, to_d;

  always_comb begin
    wd_hit = '0;
    for (int i = 0; i < NUM_ENGINES; i++)
      wd_hit[i] = busy[i] && !done_pend[i] && !eng_done[i] && (wd_cnt[i] == WD_LAST);
    to_eff = to_pend | wd_hit;
    to_d   = to_eff;
    if (rpt_any) to_d[rpt_idx] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      for (int i = 0; i < NUM_ENGINES; i++) wd_cnt[i] <= '0;
      to_pend <= '0;
      timeout <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_ENGINES; i++) begin
        if (!busy[i])
          wd_cnt[i] <= '0;
        else if (wd_cnt[i] != 16'hFFFF)
          wd_cnt[i] <= wd_cnt[i] + 16'd1;
      end
      to_pend <= to_d;
      timeout <= rpt_any && to_eff[rpt_idx];
    end
  end
`endif

  // Fresh completions join the pending set in the same cycle so a lone done reports next cycle.
  always_comb begin
    done_hit = eng_done & busy;
`ifdef DISPATCH_WATCHDOG_EN
    done_hit = done_hit | wd_hit;
`endif
    pend_eff = done_pend | done_hit;
    rpt_any  = |pend_eff;
    rpt_idx  = '0;
    for (int i = NUM_ENGINES - 1; i >= 0; i--)
      if (pend_eff[i]) rpt_idx = ENG_IDX_W'(i);
    busy_d = busy;
    pend_d = pend_eff;
    if (rpt_any) begin
      busy_d[rpt_idx] = 1'b0;
      pend_d[rpt_idx] = 1'b0;
    end
    if (issue) busy_d[sel_q] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state_q        <= ST_IDLE;
      rr_ptr         <= '0;
      sel_q          <= '0;
      busy           <= '0;
      done_pend      <= '0;
      eng_des_addr   <= '0;
      eng_comp_len   <= '0;
      eng_decomp_len <= '0;
      eng_src_addr   <= '0;
      eng_job_id     <= '0;
      done_valid     <= 1'b0;
      done_engine    <= '0;
      done_job_id    <= '0;
      spurious_done  <= 1'b0;
      for (int i = 0; i < NUM_ENGINES; i++) job_tbl[i] <= '0;
    end else begin
      state_q   <= state_d;
      busy      <= busy_d;
      done_pend <= pend_d;
      if (dispatch) begin
        eng_des_addr   <= pend_des_addr;
        eng_comp_len   <= pend_comp_len;
        eng_decomp_len <= pend_decomp_len;
        eng_src_addr   <= pend_src_addr;
        eng_job_id     <= pend_job_id;
        sel_q          <= sel_nxt;
      end
      if (issue) begin
        job_tbl[sel_q] <= eng_job_id;
        rr_ptr         <= (sel_q == ENG_IDX_W'(NUM_ENGINES - 1)) ? '0 : sel_q + 1'b1;
      end
      done_valid <= rpt_any;
      if (rpt_any) begin
        done_engine <= rpt_idx;
        done_job_id <= job_tbl[rpt_idx];
      end
      if (|(eng_done & ~busy)) spurious_done <= 1'b1;
    end
  end

endmodule

// File: tb/tb_job_dispatch_ctrl.sv
// Self-checking bench for job_dispatch_ctrl: directed scenarios plus a randomized run
// against a transaction-level reference model.
module tb_job_dispatch_ctrl;

  localparam int N = 4;

  typedef struct packed {
    logic [63:0] des;
    logic [34:0] comp;
    logic [31:0] decomp;
    logic [63:0] src;
    logic [15:0] id;
  } desc_t;

  logic        clk = 1'b0;
  logic        srst = 1'b1;
  logic        pend_valid = 1'b0;
  logic        pend_rd;
  logic [63:0] pend_des_addr = '0;
  logic [34:0] pend_comp_len = '0;
  logic [31:0] pend_decomp_len = '0;
  logic [63:0] pend_src_addr = '0;
  logic [15:0] pend_job_id = '0;
  logic        hold = 1'b0;
  logic [N-1:0] eng_start;
  logic [63:0] eng_des_addr;
  logic [34:0] eng_comp_len;
  logic [31:0] eng_decomp_len;
  logic [63:0] eng_src_addr;
  logic [15:0] eng_job_id;
  logic [N-1:0] eng_done = '0;
  logic [N-1:0] busy_mask;
  logic        done_valid;
  logic [1:0]  done_engine;
  logic [15:0] done_job_id;
  logic        spurious_done;
  logic        all_idle;
`ifdef DISPATCH_WATCHDOG_EN
  logic        timeout;
`endif

  int errors = 0;
  int checks = 0;
  desc_t q[$];

  always #5 clk = ~clk;

  job_dispatch_ctrl #(.NUM_ENGINES(N), .ENG_IDX_W(2)) dut (
    .clk             (clk),
    .srst            (srst),
    .pend_valid      (pend_valid),
    .pend_rd         (pend_rd),
    .pend_des_addr   (pend_des_addr),
    .pend_comp_len   (pend_comp_len),
    .pend_decomp_len (pend_decomp_len),
    .pend_src_addr   (pend_src_addr),
    .pend_job_id     (pend_job_id),
    .hold            (hold),
    .eng_start       (eng_start),
    .eng_des_addr    (eng_des_addr),
    .eng_comp_len    (eng_comp_len),
    .eng_decomp_len  (eng_decomp_len),
    .eng_src_addr    (eng_src_addr),
    .eng_job_id      (eng_job_id),
    .eng_done        (eng_done),
    .busy_mask       (busy_mask),
    .done_valid      (done_valid),
    .done_engine     (done_engine),
    .done_job_id     (done_job_id),
    .spurious_done   (spurious_done),
    .all_idle        (all_idle)
`ifdef DISPATCH_WATCHDOG_EN
    ,
    .timeout         (timeout)
`endif
  );

  function automatic desc_t mk_desc(input logic [15:0] id);
    desc_t d;
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    d.des = r;
    r = {$urandom(), $urandom()};
    d.comp = r[34:0];
    d.decomp = $urandom();
    r = {$urandom(), $urandom()};
    d.src = r;
    d.id = id;
    return d;
  endfunction

  task automatic drive_head();
    desc_t h;
    if (q.size() > 0) begin
      h = q[0];
      pend_valid = 1'b1;
      pend_des_addr = h.des;
      pend_comp_len = h.comp;
      pend_decomp_len = h.decomp;
      pend_src_addr = h.src;
      pend_job_id = h.id;
    end else begin
      pend_valid = 1'b0;
    end
  endtask

  // One clock: pops the queue head if the DUT read it, clears done pulses, ends at negedge.
  task automatic adv();
    logic rd;
    #1 rd = pend_rd;
    @(posedge clk);
    #1;
    if (rd && q.size() > 0) q.delete(0);
    eng_done = '0;
    drive_head();
    @(negedge clk);
  endtask

  task automatic do_reset();
    srst = 1'b1;
    hold = 1'b0;
    eng_done = '0;
    q.delete();
    drive_head();
    repeat (2) @(posedge clk);
    #1 srst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({pend_rd, eng_start, busy_mask, done_valid, spurious_done, all_idle} !== {1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_ctrl: got rd=%b start=%b busy=%b dv=%b spur=%b idle=%b expected 0 0000 0000 0 0 1",
               pend_rd, eng_start, busy_mask, done_valid, spurious_done, all_idle);
    end
    checks++;
    if ({eng_des_addr, eng_comp_len, eng_decomp_len, eng_src_addr, eng_job_id, done_engine, done_job_id} !== '0) begin
      errors++;
      $display("FAIL reset_data: got job=%h done_eng=%0d done_job=%h expected all zero", eng_job_id, done_engine, done_job_id);
    end
  endtask

  task automatic test_single_job();
    desc_t d;
    do_reset();
    d = mk_desc(16'h0011);
    q.push_back(d);
    drive_head();
    #1;
    checks++;
    if (pend_rd !== 1'b1) begin errors++; $display("FAIL single_rd: got %b expected 1", pend_rd); end
    adv();
    checks++;
    if (eng_start !== 4'b0001) begin errors++; $display("FAIL single_start: got %b expected 0001", eng_start); end
    checks++;
    if ({eng_des_addr, eng_comp_len, eng_decomp_len, eng_src_addr, eng_job_id} !== d) begin
      errors++;
      $display("FAIL single_desc: got %h expected %h", {eng_des_addr, eng_comp_len, eng_decomp_len, eng_src_addr, eng_job_id}, d);
    end
    adv();
    checks++;
    if ({busy_mask, eng_start} !== {4'b0001, 4'b0000}) begin
      errors++; $display("FAIL single_busy: got busy=%b start=%b expected 0001 0000", busy_mask, eng_start);
    end
    repeat (8) adv();
    eng_done = 4'b0001;
    adv();
    checks++;
    if ({done_valid, done_engine, done_job_id, busy_mask} !== {1'b1, 2'd0, 16'h0011, 4'b0000}) begin
      errors++;
      $display("FAIL single_done: got dv=%b eng=%0d job=%h busy=%b expected 1 0 0011 0000", done_valid, done_engine, done_job_id, busy_mask);
    end
    adv();
    checks++;
    if ({done_valid, all_idle} !== 2'b01) begin
      errors++; $display("FAIL single_idle: got dv=%b idle=%b expected 0 1", done_valid, all_idle);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int k = 0; k < 6; k++) q.push_back(mk_desc(16'h0100 + 16'(k)));
    drive_head();
    #1;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (pend_rd !== 1'b1) begin errors++; $display("FAIL rr_rd%0d: got %b expected 1", k, pend_rd); end
      adv();
      checks++;
      if ({eng_start, eng_job_id} !== {4'(1 << k), 16'h0100 + 16'(k)}) begin
        errors++; $display("FAIL rr_start%0d: got %b job %h expected %b job %h", k, eng_start, eng_job_id, 4'(1 << k), 16'h0100 + 16'(k));
      end
      adv();
    end
    repeat (3) begin
      checks++;
      if ({pend_rd, busy_mask} !== {1'b0, 4'hF}) begin
        errors++; $display("FAIL rr_full: got rd=%b busy=%b expected 0 1111", pend_rd, busy_mask);
      end
      adv();
    end
    eng_done = 4'b0100;
    adv();
    checks++;
    if ({done_valid, done_engine, done_job_id, busy_mask, pend_rd} !== {1'b1, 2'd2, 16'h0102, 4'b1011, 1'b1}) begin
      errors++;
      $display("FAIL rr_free2: got dv=%b eng=%0d job=%h busy=%b rd=%b expected 1 2 0102 1011 1",
               done_valid, done_engine, done_job_id, busy_mask, pend_rd);
    end
    adv();
    checks++;
    if ({eng_start, eng_job_id} !== {4'b0100, 16'h0104}) begin
      errors++; $display("FAIL rr_fifth: got %b job %h expected 0100 job 0104", eng_start, eng_job_id);
    end
  endtask

  task automatic test_simul_done();
    do_reset();
    for (int k = 0; k < 4; k++) q.push_back(mk_desc(16'h0200 + 16'(k)));
    drive_head();
    repeat (8) adv();
    checks++;
    if (busy_mask !== 4'hF) begin errors++; $display("FAIL sim_busy: got %b expected 1111", busy_mask); end
    eng_done = 4'b0101;
    adv();
    checks++;
    if ({done_valid, done_engine, done_job_id} !== {1'b1, 2'd0, 16'h0200}) begin
      errors++; $display("FAIL sim_rep0: got dv=%b eng=%0d job=%h expected 1 0 0200", done_valid, done_engine, done_job_id);
    end
    adv();
    checks++;
    if ({done_valid, done_engine, done_job_id, busy_mask} !== {1'b1, 2'd2, 16'h0202, 4'b1010}) begin
      errors++; $display("FAIL sim_rep2: got dv=%b eng=%0d job=%h busy=%b expected 1 2 0202 1010", done_valid, done_engine, done_job_id, busy_mask);
    end
    adv();
    eng_done = 4'b1010;
    adv();
    checks++;
    if ({done_valid, done_engine, done_job_id} !== {1'b1, 2'd1, 16'h0201}) begin
      errors++; $display("FAIL sim_rep1: got dv=%b eng=%0d job=%h expected 1 1 0201", done_valid, done_engine, done_job_id);
    end
    adv();
    checks++;
    if ({done_valid, done_engine, done_job_id, busy_mask} !== {1'b1, 2'd3, 16'h0203, 4'b0000}) begin
      errors++; $display("FAIL sim_rep3: got dv=%b eng=%0d job=%h busy=%b expected 1 3 0203 0000", done_valid, done_engine, done_job_id, busy_mask);
    end
    adv();
    checks++;
    if ({done_valid, all_idle} !== 2'b01) begin
      errors++; $display("FAIL sim_idle: got dv=%b idle=%b expected 0 1", done_valid, all_idle);
    end
  endtask

  task automatic test_hold();
    do_reset();
    hold = 1'b1;
    q.push_back(mk_desc(16'h0300));
    drive_head();
    repeat (5) begin
      #1;
      checks++;
      if (pend_rd !== 1'b0) begin errors++; $display("FAIL hold_block: got %b expected 0", pend_rd); end
      adv();
    end
    hold = 1'b0;
    #1;
    checks++;
    if (pend_rd !== 1'b1) begin errors++; $display("FAIL hold_release: got %b expected 1", pend_rd); end
    adv();
    checks++;
    if ({eng_start, eng_job_id} !== {4'b0001, 16'h0300}) begin
      errors++; $display("FAIL hold_start: got %b job %h expected 0001 job 0300", eng_start, eng_job_id);
    end
  endtask

  task automatic test_spurious_reset();
    do_reset();
    eng_done = 4'b0100;
    adv();
    checks++;
    if ({spurious_done, done_valid} !== 2'b10) begin
      errors++; $display("FAIL spur_set: got spur=%b dv=%b expected 1 0", spurious_done, done_valid);
    end
    adv();
    checks++;
    if ({spurious_done, done_valid, busy_mask} !== {2'b10, 4'b0000}) begin
      errors++; $display("FAIL spur_sticky: got spur=%b dv=%b busy=%b expected 1 0 0000", spurious_done, done_valid, busy_mask);
    end
    q.push_back(mk_desc(16'h0400));
    q.push_back(mk_desc(16'h0401));
    drive_head();
    repeat (4) adv();
    checks++;
    if (busy_mask !== 4'b0011) begin errors++; $display("FAIL spur_busy2: got %b expected 0011", busy_mask); end
    srst = 1'b1;
    q.delete();
    drive_head();
    @(posedge clk);
    #1 srst = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy_mask, all_idle, spurious_done, done_valid, eng_start} !== {4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000}) begin
      errors++;
      $display("FAIL rst_mid: got busy=%b idle=%b spur=%b dv=%b start=%b expected 0000 1 0 0 0000",
               busy_mask, all_idle, spurious_done, done_valid, eng_start);
    end
    adv();
    checks++;
    if (done_valid !== 1'b0) begin errors++; $display("FAIL rst_noreport: got %b expected 0", done_valid); end
  endtask

  // Reference model: engines are a busy set plus job ids, dones form a pending set drained
  // lowest-first one per cycle, and each popped job starts on the first free engine from the pointer.
  task automatic test_random();
    logic [N-1:0] m_busy, m_pend, exp_start;
    logic [15:0]  m_job [N];
    int           m_rr, m_sel, rpt_e;
    bit           m_issue, exp_rd, rpt_v, nxt_issue;
    logic [15:0]  rpt_j, nxt_id;
    desc_t        m_desc;
    do_reset();
    m_busy = '0; m_pend = '0; m_rr = 0; m_sel = 0; m_issue = 0;
    rpt_v = 0; rpt_e = 0; rpt_j = '0; nxt_id = 16'h1000; m_desc = '0;
    for (int i = 0; i < N; i++) m_job[i] = '0;
    for (int c = 0; c < 600; c++) begin
      if (q.size() < 3 && $urandom_range(3, 0) != 0) begin
        q.push_back(mk_desc(nxt_id));
        nxt_id++;
      end
      drive_head();
      hold = ($urandom_range(3, 0) == 0);
      eng_done = '0;
      for (int i = 0; i < N; i++)
        if (m_busy[i] && !m_pend[i] && $urandom_range(5, 0) == 0) eng_done[i] = 1'b1;
      #1;
      exp_rd = !m_issue && pend_valid && !hold && (m_busy != {N{1'b1}});
      exp_start = m_issue ? 4'(1 << m_sel) : 4'h0;
      checks++;
      if ({pend_rd, eng_start} !== {exp_rd, exp_start}) begin
        errors++; $display("FAIL rnd_ctrl c%0d: got rd=%b start=%b expected rd=%b start=%b", c, pend_rd, eng_start, exp_rd, exp_start);
      end
      if (m_issue) begin
        checks++;
        if ({eng_des_addr, eng_comp_len, eng_decomp_len, eng_src_addr, eng_job_id} !== m_desc) begin
          errors++; $display("FAIL rnd_desc c%0d: got job %h expected job %h", c, eng_job_id, m_desc.id);
        end
      end
      checks++;
      if ({busy_mask, done_valid, spurious_done} !== {m_busy, rpt_v, 1'b0}) begin
        errors++;
        $display("FAIL rnd_state c%0d: got busy=%b dv=%b spur=%b expected busy=%b dv=%b spur=0", c, busy_mask, done_valid, spurious_done, m_busy, rpt_v);
      end
      if (rpt_v) begin
        checks++;
        if ({done_engine, done_job_id} !== {2'(rpt_e), rpt_j}) begin
          errors++; $display("FAIL rnd_report c%0d: got eng=%0d job=%h expected eng=%0d job=%h", c, done_engine, done_job_id, rpt_e, rpt_j);
        end
      end
      nxt_issue = 0;
      if (m_issue) begin
        m_busy[m_sel] = 1'b1;
        m_job[m_sel] = m_desc.id;
        m_rr = (m_sel + 1) % N;
      end else if (exp_rd) begin
        for (int k = N - 1; k >= 0; k--)
          if (!m_busy[(m_rr + k) % N]) m_sel = (m_rr + k) % N;
        m_desc = q[0];
        nxt_issue = 1;
      end
      for (int i = 0; i < N; i++)
        if (eng_done[i] && m_busy[i]) m_pend[i] = 1'b1;
      rpt_v = 0;
      for (int i = N - 1; i >= 0; i--)
        if (m_pend[i]) begin rpt_v = 1; rpt_e = i; end
      if (rpt_v) begin
        rpt_j = m_job[rpt_e];
        m_pend[rpt_e] = 1'b0;
        m_busy[rpt_e] = 1'b0;
      end
      m_issue = nxt_issue;
      adv();
    end
    hold = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single_job();
    test_round_robin();
    test_simul_done();
    test_hold();
    test_spurious_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
